mlab_fifo_unpacker: RTL and testbench



---
 rtl/mlab_fifo_unpacker.sv | 101 ++++++++++
 tb/tb_mlab_fifo_unpacker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlab_fifo_unpacker.sv
// mlab_fifo_unpacker
// Drains a show-ahead FIFO of IN_WIDTH-bit words and replays each word as
// RATIO = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream. The next
// word is popped on the same cycle the last beat is accepted, so consecutive
// words stream without a bubble.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous reset, active low
//   i_flush       synchronous discard of the word being unpacked
//   i_fifo_data   FIFO head word (show-ahead, valid while !i_fifo_empty)
//   i_fifo_empty  FIFO empty flag
//   o_fifo_rdreq  FIFO pop (combinational: depends on i_ready, i_fifo_empty)
//   o_valid       beat available
//   i_ready       consumer accepts beat
//   o_data        current beat
//   o_last        current beat is the final beat of its word
//
// Build option:
//   MLAB_UNPACK_MSB_FIRST_EN  when defined, the most significant slice is
//                             emitted first; default is least significant first.

module mlab_fifo_unpacker #(
  parameter int unsigned IN_WIDTH  = 256,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  input  logic [IN_WIDTH-1:0]  i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rdreq,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_last
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  state_t                          state;
  logic [IN_WIDTH-1:0]             word;
  logic [CNT_W-1:0]                cnt;
  logic [RATIO-1:0][OUT_WIDTH-1:0] beats;
  logic                            full;
  logic                            last;
  logic                            acc;
  logic                            ld;

  // Handshake and load decision
  assign full = (state == ST_BUSY);
  assign last = full && (cnt == LAST_CNT);
  assign acc  = full && i_ready;
  // Gated by rst so no pop is issued while reset is asserted.
  assign ld   = rst && !i_fifo_empty && !i_flush && (!full || (acc && last));

  assign o_fifo_rdreq = ld;
  assign o_valid      = full;
  assign o_last       = last;

  // Beat slice selection
  assign beats = word;
`ifdef MLAB_UNPACK_MSB_FIRST_EN
  assign o_data = beats[LAST_CNT - cnt];
`else
  assign o_data = beats[cnt];
`endif

  // State, holding register and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
      word  <= '0;
      cnt   <= '0;
    end else if (i_flush) begin
      // A beat accepted in this cycle is still counted as delivered.
      state <= ST_EMPTY;
      cnt   <= '0;
    end else if (ld) begin
      // Show-ahead FIFO: head data is captured in the same cycle as the pop.
      state <= ST_BUSY;
      word  <= i_fifo_data;
      cnt   <= '0;
    end else if (acc) begin
      if (last) begin
        state <= ST_EMPTY;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mlab_fifo_unpacker.sv
module tb_mlab_fifo_unpacker;

  localparam int unsigned IW = 128;
  localparam int unsigned OW = 32;
  localparam int unsigned NB = IW / OW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_flush = 1'b0;
  logic [IW-1:0] i_fifo_data = '0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rdreq;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [OW-1:0] o_data;
  logic          o_last;

  mlab_fifo_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (i_flush),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rdreq (o_fifo_rdreq),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // FIFO contents as seen by the bench
  logic [IW-1:0] fifo_q[$];

  // Reference model: held word, index of next beat, word-held flag
  logic          m_full = 1'b0;
  logic [IW-1:0] m_word = '0;
  int            m_idx  = 0;

  // Observations from the latest step
  logic          obs_valid, obs_last, obs_rdreq;
  logic [OW-1:0] obs_data;
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_fl = 1'b0, prev_last = 1'b0;
  logic [OW-1:0] prev_data = '0;

  localparam logic [IW-1:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [IW-1:0] WB = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Beat k of a word, straight from the slice-order rule
  function automatic logic [OW-1:0] mslice(input logic [IW-1:0] w, input int k);
`ifdef MLAB_UNPACK_MSB_FIRST_EN
    return OW'(w >> (OW * (NB - 1 - k)));
`else
    return OW'(w >> (OW * k));
`endif
  endfunction

  // Hand-written beats of W1 and first beat of WB
  function automatic logic [OW-1:0] lit_w1(input int k);
    logic [OW-1:0] lits[4];
    lits = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
`ifdef MLAB_UNPACK_MSB_FIRST_EN
    return lits[3-k];
`else
    return lits[k];
`endif
  endfunction

  function automatic logic [OW-1:0] lit_wb0();
`ifdef MLAB_UNPACK_MSB_FIRST_EN
    return 32'hDDDDDDDD;
`else
    return 32'hAAAAAAAA;
`endif
  endfunction

  // One clock cycle: drive inputs, compare DUT to model, advance model
  task automatic step(input logic rdy, input logic fl, input logic mask);
    logic e_valid, e_last, e_acc, e_ld;
    @(negedge clk);
    cyc++;
    i_ready      = rdy;
    i_flush      = fl;
    i_fifo_empty = (fifo_q.size() == 0) || mask;
    i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    #1;
    e_valid = m_full;
    e_last  = m_full && (m_idx == NB - 1);
    e_acc   = e_valid && rdy;
    e_ld    = !i_fifo_empty && !fl && (!m_full || (e_acc && e_last));
    obs_valid = o_valid;
    obs_last  = o_last;
    obs_rdreq = o_fifo_rdreq;
    obs_data  = o_data;
    chk("valid", obs_valid, e_valid);
    chk("last", obs_last, e_last);
    chk("rdreq", obs_rdreq, e_ld);
    if (e_valid) chk("data", obs_data, mslice(m_word, m_idx));
    if (prev_valid && !prev_ready && !prev_fl) begin
      chk("stall_valid", obs_valid, 1'b1);
      chk("stall_data", obs_data, prev_data);
      chk("stall_last", obs_last, prev_last);
    end
    prev_valid = obs_valid;
    prev_ready = rdy;
    prev_fl    = fl;
    prev_data  = obs_data;
    prev_last  = obs_last;
    if (fl) begin
      m_full = 1'b0;
      m_idx  = 0;
    end else if (e_ld) begin
      m_word = fifo_q.pop_front();
      m_full = 1'b1;
      m_idx  = 0;
    end else if (e_acc) begin
      if (e_last) begin
        m_full = 1'b0;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  function automatic logic [IW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout cyc=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int pops;

    // Reset with a word waiting: nothing may move
    #1 rst = 1'b0;
    i_fifo_empty = 1'b0;
    i_fifo_data  = W1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_last", o_last, 1'b0);
    chk("rst_data", o_data, '0);
    chk("rst_rdreq", o_fifo_rdreq, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    i_fifo_empty = 1'b1;

    // Single word
    fifo_q.push_back(W1);
    step(1, 0, 0);
    chk("s1_rdreq", obs_rdreq, 1'b1);
    chk("s1_valid0", obs_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0);
      chk("s1_beat", obs_data, lit_w1(k));
      chk("s1_lastk", obs_last, k == 3);
    end
    step(1, 0, 0);
    chk("s1_after", obs_valid, 1'b0);

    // Back-to-back words
    for (int k = 0; k < 3; k++) fifo_q.push_back(rand_word());
    for (int i = 0; i < 13; i++) begin
      step(1, 0, 0);
      chk("b2b_rdreq", obs_rdreq, (i == 0) || (i == 4) || (i == 8));
      if (i >= 1) chk("b2b_valid", obs_valid, 1'b1);
    end
    step(1, 0, 0);
    chk("b2b_after", obs_valid, 1'b0);

    // Backpressure 1,0,0,1
    fifo_q.push_back(W1);
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      step((i % 4 == 0) || (i % 4 == 3), 0, 0);
      if (obs_rdreq) pops++;
    end
    chk("bp_pops", 128'(pops), 128'(1));
    chk("bp_after", obs_valid, 1'b0);

    // Flush mid-word with the next word present
    fifo_q.push_back(rand_word());
    fifo_q.push_back(WB);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("fl_rdreq", obs_rdreq, 1'b0);
    step(1, 0, 0);
    chk("fl_valid", obs_valid, 1'b0);
    chk("fl_reload", obs_rdreq, 1'b1);
    step(1, 0, 0);
    chk("fl_beat0", obs_data, lit_wb0());
    repeat (4) step(1, 0, 0);

    // Asynchronous reset mid-word (cnt = 2)
    fifo_q.push_back(rand_word());
    fifo_q.push_back(WB);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    @(negedge clk);
    #2;
    i_flush      = 1'b0;
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_data  = fifo_q[0];
    rst = 1'b0;
    #1;
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_data", o_data, '0);
    chk("arst_rdreq", o_fifo_rdreq, 1'b0);
    chk("arst_last", o_last, 1'b0);
    m_full = 1'b0;
    m_idx = 0;
    m_word = '0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_hold", o_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    i_fifo_empty = 1'b1;
    step(1, 0, 0);
    chk("arst_reload", obs_rdreq, 1'b1);
    step(1, 0, 0);
    chk("arst_beat0", obs_data, lit_wb0());
    repeat (4) step(1, 0, 0);

    // Empty flag pulses low for one cycle on beat 1
    fifo_q.push_back(rand_word());
    fifo_q.push_back(rand_word());
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    chk("et_nopop_b1", obs_rdreq, 1'b0);
    step(1, 0, 1);
    step(1, 0, 1);
    chk("et_nopop_last", obs_rdreq, 1'b0);
    step(1, 0, 1);
    chk("et_idle", obs_valid, 1'b0);
    step(1, 0, 0);
    chk("et_load", obs_rdreq, 1'b1);
    repeat (5) step(1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(rand_word());
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 4) == 0);
    end
    repeat (40) step(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
